// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int DATA_BITS_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    // Expected parity bit for a word; odd=1 selects odd parity.
    function automatic logic calc_parity(input logic [DATA_BITS_MAX-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_out_buf.sv
// Output holding register with valid/ready handshake and overrun detection.
module uart_rx_out_buf #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 rx_ready,
    input  logic                 clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 overrun_err
);

    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 overrun_r;
    logic                 blocked_s;
    logic                 accept_s;
    logic                 handshake_s;

    // A held word not being taken this cycle blocks any new load.
    assign blocked_s   = valid_r & ~rx_ready;
    assign accept_s    = load & ~blocked_s;
    assign handshake_s = valid_r & rx_ready;

    // Holding register and valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {DATA_BITS{1'b0}};
            valid_r <= 1'b0;
        end else if (accept_s) begin
            data_r  <= load_data;
            valid_r <= 1'b1;
        end else if (handshake_s) begin
            data_r  <= data_r;
            valid_r <= 1'b0;
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
        end
    end

    // Sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (clr) begin
            overrun_r <= 1'b0;
        end else if (load & blocked_s) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign rx_data     = data_r;
    assign rx_valid    = valid_r;
    assign overrun_err = overrun_r;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: assembles sampled bits into words and tracks frame errors.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_detected,
    input  logic                 bit_valid,
    input  logic                 bit_sample,
    input  logic                 err_clr,
    input  logic                 rx_ready,
    output logic                 frame_complete,
    output logic                 error_clear,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    rx_state_e            state_r;
    rx_state_e            state_s;
    logic [3:0]           cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 start_s;
    logic                 shift_en_s;
    logic                 stop_s;
    logic                 load_s;
    logic                 frame_complete_r;
    logic                 error_clear_r;
    logic                 framing_err_r;
`ifdef UART_RX_PARITY_EN
    logic                 par_chk_s;
    logic                 par_pend_r;
    logic                 parity_err_r;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control strobes; err_clr overrides everything.
    always_comb begin
        state_s    = state_r;
        start_s    = 1'b0;
        shift_en_s = 1'b0;
        stop_s     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk_s  = 1'b0;
`endif
        if (err_clr) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_detected) begin
                        state_s = ST_DATA;
                        start_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (bit_valid) begin
                        shift_en_s = 1'b1;
                        if (cnt_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_s = ST_PARITY;
`else
                            state_s = ST_STOP;
`endif
                        end else begin
                            state_s = ST_DATA;
                        end
                    end else begin
                        state_s = ST_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_valid) begin
                        par_chk_s = 1'b1;
                        state_s   = ST_STOP;
                    end else begin
                        state_s = ST_PARITY;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_valid) begin
                        stop_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_STOP;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    assign load_s = stop_s & bit_sample;

    // Bit counter and LSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 4'd0;
            shift_r <= {DATA_BITS{1'b0}};
        end else if (err_clr || start_s) begin
            cnt_r   <= 4'd0;
            shift_r <= {DATA_BITS{1'b0}};
        end else if (shift_en_s) begin
            cnt_r   <= cnt_r + 4'd1;
            shift_r <= {bit_sample, shift_r[DATA_BITS-1:1]};
        end else begin
            cnt_r   <= cnt_r;
            shift_r <= shift_r;
        end
    end

    // Sampler pulses and sticky framing error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_complete_r <= 1'b0;
            error_clear_r    <= 1'b0;
            framing_err_r    <= 1'b0;
        end else begin
            frame_complete_r <= stop_s;
            error_clear_r    <= err_clr;
            if (err_clr) begin
                framing_err_r <= 1'b0;
            end else if (stop_s && !bit_sample) begin
                framing_err_r <= 1'b1;
            end else begin
                framing_err_r <= framing_err_r;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // A parity mismatch stays pending until the stop bit decides whether the word is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_pend_r   <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            if (err_clr || start_s) begin
                par_pend_r <= 1'b0;
            end else if (par_chk_s) begin
                par_pend_r <= bit_sample ^ calc_parity(DATA_BITS_MAX'(shift_r), PARITY_ODD);
            end else begin
                par_pend_r <= par_pend_r;
            end
            if (err_clr) begin
                parity_err_r <= 1'b0;
            end else if (load_s && par_pend_r) begin
                parity_err_r <= 1'b1;
            end else begin
                parity_err_r <= parity_err_r;
            end
        end
    end

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    uart_rx_out_buf #(
        .DATA_BITS (DATA_BITS)
    ) u_out_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load_s),
        .load_data   (shift_r),
        .rx_ready    (rx_ready),
        .clr         (err_clr),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .overrun_err (overrun_err)
    );

    assign frame_complete = frame_complete_r;
    assign error_clear    = error_clear_r;
    assign framing_err    = framing_err_r;

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..8).
REQ-002 SHALL have parameter PARITY_ODD, default 0, where 1 = odd parity and 0 = even parity (used only with UART_RX_PARITY_EN).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_detected  input  1  one-cycle pulse from bit sampler: valid start bit.
REQ-006 SHALL have port bit_valid  input  1  one-cycle pulse: bit_sample holds a new data, parity or stop bit.
REQ-007 SHALL have port bit_sample  input  1  sampled bit value.
REQ-008 SHALL have port err_clr  input  1  software clear of sticky errors and frame abort.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data.
REQ-010 SHALL have port frame_complete  output  1  one-cycle pulse to the sampler: frame finished.
REQ-011 SHALL have port error_clear  output  1  one-cycle pulse to the sampler: abort or clear.
REQ-012 SHALL have port rx_data  output  DATA_BITS  received word, LSB-first assembled.
REQ-013 SHALL have port rx_valid  output  1  rx_data valid, held until accepted.
REQ-014 SHALL have port framing_err, parity_err, overrun_err  output  1 each  sticky error flags.

Function
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-016 SHALL move IDLE->DATA on start_detected, clearing the bit counter and shift register.
REQ-017 In DATA, each bit_valid SHALL shift bit_sample in at MSB and shift right, so the first bit ends at bit 0. After DATA_BITS pulses the FSM SHALL go to PARITY if enabled, else STOP.
REQ-018 In PARITY, bit_valid SHALL compare the received bit with the computed parity and go to STOP; a mismatch SHALL flag a pending parity error.
REQ-019 In STOP, bit_valid SHALL pulse frame_complete in the next cycle and return to IDLE.
REQ-020 If stop bit = 0: the word SHALL be discarded and framing_err set; any pending parity error SHALL be dropped.
REQ-021 If stop bit = 1: the word SHALL load the output buffer 1 cycle after the stop bit_valid, with rx_valid rising the same cycle. A pending parity error SHALL set parity_err and the data SHALL still be delivered.
REQ-022 A handshake SHALL complete when rx_valid && rx_ready; rx_valid then SHALL drop next cycle unless a new word loads that same cycle.
REQ-023 If a load occurs while rx_valid && !rx_ready: the new word SHALL be dropped, the old word kept, and overrun_err set.
REQ-024 A load in the same cycle as rx_ready SHALL replace the data with no overrun, and rx_valid SHALL stay high.
REQ-025 err_clr SHALL clear all three error flags, force the FSM to IDLE, discard the partial word, and pulse error_clear next cycle. The rx_valid buffer SHALL be unaffected.
REQ-026 start_detected outside IDLE SHALL be ignored. bit_valid in IDLE SHALL be ignored.
REQ-027 If err_clr and a stop bit_valid coincide, err_clr SHALL win and no load SHALL occur.

Reset
REQ-028 On rst_n low: FSM = IDLE, counter = 0, rx_data = 0, rx_valid = 0, all error flags = 0, frame_complete = 0, error_clear = 0.
REQ-029 Reset mid-frame SHALL discard the partial frame, with no frame_complete pulse.

Configuration
REQ-030 With UART_RX_PARITY_EN defined: the PARITY state and parity_err logic SHALL be present.
REQ-031 Without UART_RX_PARITY_EN: the PARITY state SHALL be unreachable, DATA SHALL go directly to STOP, and parity_err SHALL be tied 0.

Structure
REQ-032 Package uart_rx_pkg SHALL hold the FSM state enum and the default DATA_BITS constant.
REQ-033 The output holding register, valid/ready handshake and overrun detection SHALL be sub-module uart_rx_out_buf.

Verification
REQ-034 Scenario: 8N1, bits of 0xA5, stop=1 -> rx_data=0xA5, rx_valid 1 cycle after the stop pulse, frame_complete single pulse.
REQ-035 Scenario: parity enabled (even), 0x03 with parity bit 1 -> parity_err=1, rx_data=0x03 still delivered.
REQ-036 Scenario: 0x55 with stop=0 -> framing_err=1, rx_valid stays 0.
REQ-037 Scenario: 0x11 then 0x22, rx_ready held 0 -> rx_data=0x11, overrun_err=1; with rx_ready=1 coincident with the 0x22 load -> rx_data=0x22, overrun_err=0.
REQ-038 Scenario: err_clr after 3 data bits -> error_clear pulse next cycle, FSM IDLE, flags 0; a following frame 0x7E is received correctly.
REQ-039 Scenario: rst_n asserted mid-frame -> all outputs at reset values, no frame_complete pulse.
